// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b datapath types for the indirect access sequencer
package lc3b_types;
  typedef enum logic [1:0] {IND_IDLE, IND_PTR_RD, IND_FINAL, IND_DONE} ind_state_t;
  localparam int IND_MAX_LEVELS_DEFAULT = 2;
endpackage

// File: rtl/indirect_addr_reg.sv
// indirect_addr_reg: memory address register loaded from base or from an aligned pointer
module indirect_addr_reg #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_base,
  input  logic              ld_ptr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:1] ptr,
  output logic [ADDR_W-1:0] addr
);
  // base wins over pointer; otherwise hold so the address is stable while waiting
  always_ff @(posedge clk)
    if (!rst_n) addr <= '0;
    else if (ld_base) addr <= base;
    else if (ld_ptr) addr <= {ptr, 1'b0};
endmodule

// File: rtl/indirect_access_seq.sv
// indirect_access_seq: multi-level pointer dereference then final load/store (null abort under IND_NULL_CHECK_EN)
module indirect_access_seq
  import lc3b_types::*;
#(
  parameter  int ADDR_W     = 16,
  parameter  int DATA_W     = 16,
  parameter  int MAX_LEVELS = IND_MAX_LEVELS_DEFAULT,
  localparam int LVL_W      = $clog2(MAX_LEVELS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LVL_W-1:0]  levels,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] load_data,
  output logic              fault
);
  ind_state_t       state;
  logic [LVL_W-1:0] lvl_cnt;
  logic [LVL_W-1:0] lvl_clamp;
  logic             is_store_q;
  logic             strobe;
  logic             take;
  logic             ld_base;
  logic             ptr_take;
  logic             null_ptr;
  assign lvl_clamp = levels > LVL_W'(MAX_LEVELS) ? LVL_W'(MAX_LEVELS) : levels;
  assign strobe    = mem_read | mem_write;
  assign take      = strobe & mem_resp;
  assign ld_base   = state == IND_IDLE && start;
  assign ptr_take  = state == IND_PTR_RD && take;
`ifdef IND_NULL_CHECK_EN
  assign null_ptr  = ptr_take && mem_rdata[ADDR_W-1:1] == '0;
`else
  assign null_ptr  = 1'b0;
`endif
  indirect_addr_reg #(.ADDR_W(ADDR_W)) u_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_base(ld_base),
    .ld_ptr (ptr_take),
    .base   (base_addr),
    .ptr    (mem_rdata[ADDR_W-1:1]),
    .addr   (mem_address)
  );
  // sequencer: a strobe rises only from a low strobe, so every request is preceded by an idle cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IND_IDLE;
      lvl_cnt    <= '0;
      is_store_q <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      load_data  <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IND_IDLE: if (start) begin
          mem_wdata  <= store_data;
          is_store_q <= is_store;
          lvl_cnt    <= lvl_clamp;
          busy       <= 1'b1;
          state      <= lvl_clamp == '0 ? IND_FINAL : IND_PTR_RD;
        end
        IND_PTR_RD: if (take) begin
          mem_read <= 1'b0;
          lvl_cnt  <= lvl_cnt - 1'b1;
          if (null_ptr) begin
            state <= IND_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            fault <= 1'b1;
          end else if (lvl_cnt == LVL_W'(1)) state <= IND_FINAL;
        end else if (!strobe) mem_read <= 1'b1;
        IND_FINAL: if (take) begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= IND_DONE;
          if (!is_store_q) load_data <= mem_rdata;
        end else if (!strobe) begin
          mem_read  <= !is_store_q;
          mem_write <= is_store_q;
        end
        IND_DONE: state <= IND_IDLE;
        default:  state <= IND_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_indirect_access_seq.sv
// tb_indirect_access_seq: table-driven bench with a wait-state memory model for indirect_access_seq
module tb_indirect_access_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  levels = '0;
  logic        is_store = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] store_data = '0;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_read, mem_write, busy, done, fault;
  logic [15:0] mem_address, mem_wdata, load_data;
  int compared = 0;
  int mismatched = 0;
  logic [15:0] mem [logic [15:0]];
  logic [15:0] rd_log[$];
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  int delay = 0;
  int wcnt = 0;
  logic held = 1'b0;
  logic [33:0] snap = '0;
  typedef struct {
    logic [1:0]  lv;
    logic        st;
    logic [15:0] base;
    logic [15:0] sdata;
    int          dly;
    int          n_rd;
    int          n_wr;
    logic [15:0] last_addr;
    logic [15:0] ld;
    logic [15:0] wd;
    int          lat;
    logic        flt;
  } vec_t;
  vec_t v[6];
  vec_t after_rst;
  always #5 clk = ~clk;
  indirect_access_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .levels     (levels),
    .is_store   (is_store),
    .base_addr  (base_addr),
    .store_data (store_data),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .fault      (fault)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // memory model: answers after 'delay' extra strobe cycles and checks the request holds steady meanwhile
  always @(negedge clk) begin
    if (held && (mem_read || mem_write)) check("strobe_hold", {mem_read, mem_write, mem_address, mem_wdata}, snap);
    held = 1'b0;
    mem_resp = 1'b0;
    if (mem_read || mem_write) begin
      if (wcnt == delay) begin
        mem_resp = 1'b1;
        wcnt = 0;
        if (mem_read) begin
          mem_rdata = mem.exists(mem_address) ? mem[mem_address] : 16'h0;
          rd_log.push_back(mem_address);
        end else begin
          mem[mem_address] = mem_wdata;
          wr_addr.push_back(mem_address);
          wr_data.push_back(mem_wdata);
        end
      end else begin
        wcnt++;
        held = 1'b1;
        snap = {mem_read, mem_write, mem_address, mem_wdata};
      end
    end else wcnt = 0;
  end
  task automatic run(input vec_t t, input string nm);
    int cyc;
    rd_log.delete();
    wr_addr.delete();
    wr_data.delete();
    delay = t.dly;
    @(negedge clk);
    levels = t.lv;
    is_store = t.st;
    base_addr = t.base;
    store_data = t.sdata;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({nm, "_busy_early"}, busy, 1);
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_latency"}, cyc, t.lat);
    check({nm, "_busy_at_done"}, busy, 0);
    check({nm, "_fault"}, fault, t.flt);
    check({nm, "_load_data"}, load_data, t.ld);
    check({nm, "_reads"}, rd_log.size(), t.n_rd);
    check({nm, "_writes"}, wr_addr.size(), t.n_wr);
    if (rd_log.size() > 0) check({nm, "_first_addr"}, rd_log[0], t.lv == 0 ? t.base : t.base);
    if (wr_addr.size() > 0) begin
      check({nm, "_last_addr"}, wr_addr[wr_addr.size()-1], t.last_addr);
      check({nm, "_wdata"}, wr_data[wr_data.size()-1], t.wd);
    end else if (rd_log.size() > 0) check({nm, "_last_addr"}, rd_log[rd_log.size()-1], t.last_addr);
    @(negedge clk);
    check({nm, "_done_one_cycle"}, {done, fault}, 2'b00);
  endtask
  initial begin
    int k;
    mem[16'h3000] = 16'h4001;
    mem[16'h4000] = 16'h5000;
    mem[16'h5000] = 16'hBEEF;
    mem[16'h2000] = 16'h6003;
    mem[16'h7000] = 16'h8000;
    mem[16'h8000] = 16'h1357;
    mem[16'h9000] = 16'h0001;
    mem[16'h0000] = 16'hC0DE;
    v[0] = '{2'd2, 1'b0, 16'h3000, 16'h0000, 0, 3, 0, 16'h5000, 16'hBEEF, 16'h0000, 7, 1'b0};
    v[1] = '{2'd0, 1'b1, 16'h1234, 16'hA5A5, 0, 0, 1, 16'h1234, 16'hBEEF, 16'hA5A5, 3, 1'b0};
    v[2] = '{2'd1, 1'b1, 16'h2000, 16'h1111, 5, 1, 1, 16'h6002, 16'hBEEF, 16'h1111, 15, 1'b0};
    v[3] = '{2'd3, 1'b0, 16'h3000, 16'h0000, 0, 3, 0, 16'h5000, 16'hBEEF, 16'h0000, 7, 1'b0};
    v[4] = '{2'd1, 1'b0, 16'h7000, 16'h0000, 0, 2, 0, 16'h8000, 16'h1357, 16'h0000, 5, 1'b0};
`ifdef IND_NULL_CHECK_EN
    v[5] = '{2'd1, 1'b0, 16'h9000, 16'h0000, 0, 1, 0, 16'h9000, 16'h1357, 16'h0000, 3, 1'b1};
`else
    v[5] = '{2'd1, 1'b0, 16'h9000, 16'h0000, 0, 2, 0, 16'h0000, 16'hC0DE, 16'h0000, 5, 1'b0};
`endif
    after_rst = '{2'd0, 1'b0, 16'h5000, 16'h0000, 0, 1, 0, 16'h5000, 16'hBEEF, 16'h0000, 3, 1'b0};
    repeat (2) @(negedge clk);
    check("reset_ctrl", {mem_read, mem_write, busy, done, fault}, 5'b0);
    check("reset_addr", mem_address, 16'h0);
    check("reset_wdata", mem_wdata, 16'h0);
    check("reset_load", load_data, 16'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) run(v[i], $sformatf("v%0d", i));
    rd_log.delete();
    delay = 0;
    @(negedge clk);
    levels = 2'd2;
    is_store = 1'b0;
    base_addr = 16'h3000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(mem_read && mem_address == 16'h4000) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach_second_ptr", k < 50, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_ctrl", {mem_read, mem_write, busy, done, fault}, 5'b0);
    check("rst_mid_addr", mem_address, 16'h0);
    check("rst_mid_load", load_data, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", {done, busy, mem_read}, 3'b0);
    end
    run(after_rst, "after_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
